// File: rtl/pc_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit_pkg
// Description : Shared FSM state encoding and PC increment for the PC stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_branch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int PC_INCR = 4;

endpackage : pc_branch_unit_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_sel
// Description : Combinational next-PC adder/mux (pc+4, branch, jump targets).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import pc_branch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch,
    input  logic              bne,
    input  logic              zero,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic [ADDR_W-1:0] offset_sl2,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] next_pc,
    output logic              take
);

    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_jmp_target;
    logic [ADDR_W-1:0] w_sel;
    logic              w_taken;

    assign pc_plus4     = pc + ADDR_W'(PC_INCR);
    assign w_br_target  = pc_plus4 + offset_sl2;
    // Region bits above the 28-bit jump window are inherited from pc+4.
    assign w_jmp_target = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
    assign w_taken      = branch & (zero ^ bne);
    assign take         = jump | w_taken;

    always_comb begin
        w_sel = pc_plus4;
        if (jump) begin
            w_sel = w_jmp_target;
        end else if (w_taken) begin
            w_sel = w_br_target;
        end
    end

    // Keep the PC word aligned even if the offset carries stray low bits.
    assign next_pc = {w_sel[ADDR_W-1:2], 2'b00};

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit
// Description : PC register, fetch/decide sequencer and taken-branch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              dec_valid,
    input  logic              branch,
    input  logic              bne,
    input  logic              zero,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic [ADDR_W-1:0] offset_sl2,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              branch_taken,
    output logic [CNT_W-1:0]  taken_count
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_pc_load;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_take;
    logic              r_branch_taken;
    logic [CNT_W-1:0]  r_taken_count;

    pc_next_sel #(
        .ADDR_W(ADDR_W)
    ) u_next_sel (
        .pc         (r_pc),
        .branch     (branch),
        .bne        (bne),
        .zero       (zero),
        .jump       (jump),
        .jump_index (jump_index),
        .offset_sl2 (offset_sl2),
        .pc_plus4   (pc_plus4),
        .next_pc    (w_next_pc),
        .take       (w_take)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_load    = 1'b0;
        case (r_state)
            ST_IDLE:   w_state_next = ST_FETCH;
            ST_FETCH:  if (imem_ack) w_state_next = ST_DECIDE;
            ST_DECIDE: begin
                if (dec_valid) begin
                    w_pc_load    = 1'b1;
                    w_state_next = halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_pc           <= RESET_PC;
            r_branch_taken <= 1'b0;
            r_taken_count  <= '0;
        end else begin
            r_state        <= w_state_next;
            r_branch_taken <= w_pc_load & w_take;
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            // Saturate rather than wrap so the statistic never under-reports.
            if (w_pc_load && w_take && (r_taken_count != '1)) begin
                r_taken_count <= r_taken_count + CNT_W'(1);
            end
        end
    end

    assign imem_req     = (r_state == ST_FETCH);
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign branch_taken = r_branch_taken;
    assign taken_count  = r_taken_count;

endmodule : pc_branch_unit
`default_nettype wire
